// File: rtl/uart_mmio_bridge_pkg.sv
// Shared constants, state encodings and sizing helper for the UART-to-MMIO debug bridge.
package uart_mmio_bridge_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
  localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_UNK = 8'h3F;  // '?'
  localparam logic [7:0] RSP_TMO = 8'h54;  // 'T'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // Bits needed for a counter running 0..n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_mmio_bridge_rx.sv
// 8N1 UART receiver: two-flop synchroniser, glitch-filtered start detect, mid-bit sampling.
module uart_mmio_bridge_rx
  import uart_mmio_bridge_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;

  rx_state_e        state_q, state_d;
  logic [2:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             rx_line;
  logic             rx_fall;

  // sync_q[1] is the synchronised line; sync_q[2] its previous value for edge detection.
  assign rx_line = sync_q[1];
  assign rx_fall = sync_q[2] & ~sync_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RX_IDLE;
      sync_q  <= 3'b111;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[1:0], rx_i};
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_fall) state_d = RX_START;
      end
      RX_START: begin
        // A start bit that is high again at its midpoint was a glitch.
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_line ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          shift_d = {rx_line, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          state_d = RX_IDLE;
          valid_d = rx_line;
          err_d   = ~rx_line;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = err_q;

endmodule

// File: rtl/uart_mmio_bridge.sv
// UART-to-MMIO debug bridge: 'W'/'R' command frames become single 32-bit bus transactions.
// Define UART_MMIO_BRIDGE_TIMEOUT_EN to abort stalled bus transactions after TIMEOUT_CYCLES.
module uart_mmio_bridge
  import uart_mmio_bridge_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter int unsigned BAUD           = 115200,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        cmd_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = cnt_width(CLKS_PER_BIT);

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("uart_mmio_bridge: CLK_FREQ/BAUD must be at least 4");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("uart_mmio_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ferr;

  uart_mmio_bridge_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .rx_i        (uart_rx),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .frame_err_o (rx_ferr)
  );

  state_e           state_q, state_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic             is_wr_q, is_wr_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      resp_q, resp_d;
  logic [1:0]       resp_left_q, resp_left_d;
  logic             mem_valid_q, mem_valid_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             cmd_err_q, cmd_err_d;
  logic             busy_q, busy_d;
  logic [9:0]       tx_sh_q, tx_sh_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;

  logic             rsp_go;
  logic [7:0]       rsp_byte;
  logic [31:0]      rsp_rest;
  logic [1:0]       rsp_left;

`ifdef UART_MMIO_BRIDGE_TIMEOUT_EN
  localparam int unsigned TMO_W = cnt_width(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_ff @(posedge clk) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= '0;
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_q      <= '0;
      resp_left_q <= '0;
      mem_valid_q <= 1'b0;
      wstrb_q     <= '0;
      cmd_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      tx_sh_q     <= '1;
      tx_bit_q    <= '0;
      tx_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      resp_q      <= resp_d;
      resp_left_q <= resp_left_d;
      mem_valid_q <= mem_valid_d;
      wstrb_q     <= wstrb_d;
      cmd_err_q   <= cmd_err_d;
      busy_q      <= busy_d;
      tx_sh_q     <= tx_sh_d;
      tx_bit_q    <= tx_bit_d;
      tx_cnt_q    <= tx_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    resp_d      = resp_q;
    resp_left_d = resp_left_q;
    mem_valid_d = mem_valid_q;
    wstrb_d     = wstrb_q;
    cmd_err_d   = 1'b0;
    tx_sh_d     = tx_sh_q;
    tx_bit_d    = tx_bit_q;
    tx_cnt_d    = tx_cnt_q;
    rsp_go      = 1'b0;
    rsp_byte    = '0;
    rsp_rest    = '0;
    rsp_left    = '0;
`ifdef UART_MMIO_BRIDGE_TIMEOUT_EN
    tmo_d       = '0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_byte == CMD_WR || rx_byte == CMD_RD) begin
            state_d    = ST_ADDR;
            is_wr_d    = (rx_byte == CMD_WR);
            byte_cnt_d = '0;
            wdata_d    = '0;
          end else begin
            cmd_err_d = 1'b1;
            rsp_go    = 1'b1;
            rsp_byte  = RSP_UNK;
          end
        end else if (rx_ferr) begin
          cmd_err_d = 1'b1;
        end
      end

      ST_ADDR, ST_DATA: begin
        if (rx_ferr) begin
          cmd_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (rx_valid) begin
          // Operands arrive LSB first: shift each byte in from the top.
          if (state_q == ST_ADDR) addr_d  = {rx_byte, addr_q[31:8]};
          else                    wdata_d = {rx_byte, wdata_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (state_q == ST_ADDR && is_wr_q) begin
              state_d = ST_DATA;
            end else begin
              state_d     = ST_BUS;
              mem_valid_d = 1'b1;
              wstrb_d     = is_wr_q ? 4'hF : 4'h0;
            end
          end
        end
      end

      ST_BUS: begin
        if (mem_ready && mem_valid_q) begin
          mem_valid_d = 1'b0;
          wstrb_d     = '0;
          wdata_d     = '0;
          rsp_go      = 1'b1;
          if (is_wr_q) begin
            rsp_byte = RSP_OK;
          end else begin
            rsp_byte = mem_rdata[7:0];
            rsp_rest = {8'h00, mem_rdata[31:8]};
            rsp_left = 2'd3;
          end
        end
`ifdef UART_MMIO_BRIDGE_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          mem_valid_d = 1'b0;
          wstrb_d     = '0;
          wdata_d     = '0;
          cmd_err_d   = 1'b1;
          rsp_go      = 1'b1;
          rsp_byte    = RSP_TMO;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end

      ST_RESP: begin
        tx_cnt_d = tx_cnt_q + CNT_W'(1);
        if (tx_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          tx_cnt_d = '0;
          tx_sh_d  = {1'b1, tx_sh_q[9:1]};
          tx_bit_d = tx_bit_q + 4'd1;
          // End of stop bit: chain the next byte with no idle gap.
          if (tx_bit_q == 4'd9) begin
            if (resp_left_q != 2'd0) begin
              tx_sh_d     = {1'b1, resp_q[7:0], 1'b0};
              resp_d      = {8'h00, resp_q[31:8]};
              resp_left_d = resp_left_q - 2'd1;
              tx_bit_d    = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (rsp_go) begin
      state_d     = ST_RESP;
      tx_sh_d     = {1'b1, rsp_byte, 1'b0};
      tx_bit_d    = '0;
      tx_cnt_d    = '0;
      resp_d      = rsp_rest;
      resp_left_d = rsp_left;
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign uart_tx   = tx_sh_q[0];
  assign mem_valid = mem_valid_q;
  assign mem_instr = 1'b0;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign busy      = busy_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed, table-driven bench for uart_mmio_bridge at 10 clocks per bit.
module tb_uart_mmio_bridge;

  localparam int CPB = 10;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    int          ready_at;
    bit          extra;
    int          exp_n;
    logic [31:0] exp_rsp;
    bit          exp_bus;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    int          exp_vcyc;
    int          exp_err;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        uart_rx;
  logic        uart_tx;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        cmd_err;

  uart_mmio_bridge #(
    .CLK_FREQ      (1_000_000),
    .BAUD          (100_000),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .mem_valid(mem_valid),
    .mem_instr(mem_instr),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Slave model state
  int          ready_at = 0;
  logic [31:0] slave_rdata = '0;
  int          vcnt = 0;
  int          last_vcnt = 0;
  int          bus_cnt = 0;
  bit          unstable = 0;
  logic [31:0] cap_addr = '0;
  logic [31:0] cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;

  // Observers
  int         err_cnt = 0;
  logic [7:0] tx_q[$];
  int         tx_t[$];
  int         tx_stop_bad = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (cmd_err) err_cnt++;
  end

  // Bus slave: asserts ready in the ready_at-th valid cycle, garbage rdata otherwise.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'h0BAD_0BAD;
    forever begin
      @(negedge clk);
      if (mem_valid) begin
        if (vcnt == 0) begin
          bus_cnt++;
          cap_addr  = mem_addr;
          cap_wdata = mem_wdata;
          cap_wstrb = mem_wstrb;
        end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata || mem_wstrb !== cap_wstrb) begin
          unstable = 1;
        end
        vcnt++;
        last_vcnt = vcnt;
        mem_ready = (ready_at != 0 && vcnt == ready_at);
        mem_rdata = mem_ready ? slave_rdata : 32'h0BAD_0BAD;
      end else begin
        vcnt      = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0BAD_0BAD;
      end
    end
  end

  // UART TX decoder sampling mid-bit
  initial begin
    logic [7:0] b;
    int         t0;
    forever begin
      @(negedge clk);
      if (uart_tx == 1'b0) begin
        t0 = cyc;
        b  = '0;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        if (uart_tx !== 1'b1) tx_stop_bad++;
        tx_q.push_back(b);
        tx_t.push_back(t0);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, busy, 1'b0);
  endtask

  task automatic run_txn(input int k, input txn_t v);
    int          n;
    logic [31:0] a;
    ready_at    = v.ready_at;
    slave_rdata = v.rdata;
    bus_cnt     = 0;
    unstable    = 0;
    last_vcnt   = 0;
    err_cnt     = 0;
    tx_q.delete();
    tx_t.delete();
    send_byte(v.cmd, 1'b1);
    if (v.cmd == 8'h57 || v.cmd == 8'h52) send_word(v.addr);
    if (v.cmd == 8'h57) send_word(v.data);
    if (v.extra) send_byte(8'h55, 1'b1);
    n = 0;
    while (tx_q.size() < v.exp_n && n < 3000) begin
      @(negedge clk);
      n++;
    end
    wait_idle($sformatf("v%0d_idle", k));
    chk($sformatf("v%0d_rsp_cnt", k), tx_q.size(), v.exp_n);
    for (int i = 0; i < v.exp_n; i++) begin
      a = 32'hFFFF_FFFF;
      if (i < tx_q.size()) a = {24'h0, tx_q[i]};
      chk($sformatf("v%0d_rsp%0d", k, i), a, {24'h0, v.exp_rsp[8*i +: 8]});
    end
    for (int i = 1; i < tx_t.size(); i++)
      chk($sformatf("v%0d_gap%0d", k, i), tx_t[i] - tx_t[i-1], 10 * CPB);
    chk($sformatf("v%0d_bus_cnt", k), bus_cnt, v.exp_bus ? 1 : 0);
    if (v.exp_bus) begin
      chk($sformatf("v%0d_addr", k), cap_addr, v.addr);
      chk($sformatf("v%0d_wdata", k), cap_wdata, v.exp_wdata);
      chk($sformatf("v%0d_wstrb", k), {28'h0, cap_wstrb}, {28'h0, v.exp_wstrb});
      chk($sformatf("v%0d_stable", k), {31'h0, unstable}, 32'h0);
      chk($sformatf("v%0d_vcyc", k), last_vcnt, v.exp_vcyc);
      chk($sformatf("v%0d_wstrb_clr", k), {28'h0, mem_wstrb}, 32'h0);
      chk($sformatf("v%0d_wdata_clr", k), mem_wdata, 32'h0);
    end
    chk($sformatf("v%0d_err", k), err_cnt, v.exp_err);
    chk($sformatf("v%0d_tx_idle", k), uart_tx, 1'b1);
  endtask

  txn_t vec[6];
  txn_t rd_after_ferr;
  txn_t tmo_a;
  txn_t tmo_b;

  initial begin
    int n;
    vec[0] = '{cmd:8'h57, addr:32'h8000_1000, data:32'h0000_0041, rdata:32'h0, ready_at:3, extra:0,
               exp_n:1, exp_rsp:32'h4B, exp_bus:1, exp_wdata:32'h0000_0041, exp_wstrb:4'hF, exp_vcyc:3, exp_err:0};
    vec[1] = '{cmd:8'h52, addr:32'h8000_1008, data:32'h0, rdata:32'hA5B6_C7D8, ready_at:1, extra:0,
               exp_n:4, exp_rsp:32'hA5B6_C7D8, exp_bus:1, exp_wdata:32'h0, exp_wstrb:4'h0, exp_vcyc:1, exp_err:0};
    vec[2] = '{cmd:8'h55, addr:32'h0, data:32'h0, rdata:32'h0, ready_at:1, extra:0,
               exp_n:1, exp_rsp:32'h3F, exp_bus:0, exp_wdata:32'h0, exp_wstrb:4'h0, exp_vcyc:0, exp_err:1};
    vec[3] = '{cmd:8'h57, addr:32'h0000_0003, data:32'hDEAD_BEEF, rdata:32'h0, ready_at:1, extra:0,
               exp_n:1, exp_rsp:32'h4B, exp_bus:1, exp_wdata:32'hDEAD_BEEF, exp_wstrb:4'hF, exp_vcyc:1, exp_err:0};
    vec[4] = '{cmd:8'h52, addr:32'hFFFF_FFFC, data:32'h0, rdata:32'h1234_5678, ready_at:5, extra:0,
               exp_n:4, exp_rsp:32'h1234_5678, exp_bus:1, exp_wdata:32'h0, exp_wstrb:4'h0, exp_vcyc:5, exp_err:0};
    vec[5] = '{cmd:8'h57, addr:32'h0000_0100, data:32'h0000_A5A5, rdata:32'h0, ready_at:12, extra:1,
               exp_n:1, exp_rsp:32'h4B, exp_bus:1, exp_wdata:32'h0000_A5A5, exp_wstrb:4'hF, exp_vcyc:12, exp_err:0};
    rd_after_ferr = '{cmd:8'h52, addr:32'h0000_0010, data:32'h0, rdata:32'hCAFE_F00D, ready_at:2, extra:0,
               exp_n:4, exp_rsp:32'hCAFE_F00D, exp_bus:1, exp_wdata:32'h0, exp_wstrb:4'h0, exp_vcyc:2, exp_err:0};
    tmo_a  = '{cmd:8'h52, addr:32'h0000_0040, data:32'h0, rdata:32'h0, ready_at:0, extra:0,
               exp_n:1, exp_rsp:32'h54, exp_bus:1, exp_wdata:32'h0, exp_wstrb:4'h0, exp_vcyc:16, exp_err:1};
    tmo_b  = '{cmd:8'h52, addr:32'h0000_0044, data:32'h0, rdata:32'h0102_0304, ready_at:16, extra:0,
               exp_n:4, exp_rsp:32'h0102_0304, exp_bus:1, exp_wdata:32'h0, exp_wstrb:4'h0, exp_vcyc:16, exp_err:0};

    uart_rx = 1'b1;
    reset   = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_uart_tx", uart_tx, 1'b1);
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_err", cmd_err, 1'b0);
    chk("mem_instr", mem_instr, 1'b0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    for (int k = 0; k < 6; k++) run_txn(k, vec[k]);

    // Frame error after 'W', then a normal read
    err_cnt = 0;
    bus_cnt = 0;
    tx_q.delete();
    send_byte(8'h57, 1'b1);
    send_byte(8'h12, 1'b0);
    repeat (30) @(negedge clk);
    chk("ferr_err", err_cnt, 1);
    chk("ferr_busy", busy, 1'b0);
    chk("ferr_no_bus", bus_cnt, 0);
    chk("ferr_no_rsp", tx_q.size(), 0);
    run_txn(10, rd_after_ferr);

    // Reset while a write is stalled on the bus
    ready_at = 0;
    send_byte(8'h57, 1'b1);
    send_word(32'h1122_3344);
    send_word(32'h5566_7788);
    n = 0;
    while (!mem_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rstbus_valid_up", mem_valid, 1'b1);
    chk("rstbus_wstrb_up", {28'h0, mem_wstrb}, 32'hF);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rstbus_valid", mem_valid, 1'b0);
    chk("rstbus_busy", busy, 1'b0);
    chk("rstbus_tx", uart_tx, 1'b1);
    chk("rstbus_wstrb", {28'h0, mem_wstrb}, 32'h0);
    chk("rstbus_wdata", mem_wdata, 32'h0);
    chk("rstbus_addr", mem_addr, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    run_txn(11, vec[1]);

`ifdef UART_MMIO_BRIDGE_TIMEOUT_EN
    run_txn(20, tmo_a);
    run_txn(21, tmo_b);
`endif

    chk("tx_stop_bits", tx_stop_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
